// File: rtl/bb_sweep_pkg.sv
// bb_sweep_pkg
// Shared types and constants for the breadboard sweep controller.
//   state_t        : sweep FSM state encoding
//   F2_BIT..F7_BIT : bit positions of {f2,f3,f4,f7} within f_in / res_f
package bb_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int F2_BIT = 3;
    localparam int F3_BIT = 2;
    localparam int F4_BIT = 1;
    localparam int F7_BIT = 0;

endpackage

// File: rtl/bb_sweep_ctrl_golden.sv
// bb_golden
// Combinational expected-value model of the breadboard block.
// Ports:
//   idx   in  4  vector applied as {w,x,y,z}
//   f_exp out 4  expected {f2,f3,f4,f7}
module bb_golden
    import bb_sweep_pkg::*;
(
    input  logic [3:0] idx,
    output logic [3:0] f_exp
);

    logic       w, x, y, z;
    logic [2:0] pop;

    assign {w, x, y, z} = idx;
    assign pop = {2'b00, w} + {2'b00, x} + {2'b00, y} + {2'b00, z};

    always_comb begin
        f_exp         = 4'b0000;
        f_exp[F2_BIT] = (pop >= 3'd3);
        f_exp[F3_BIT] = (w & z) | (x & y);
        f_exp[F4_BIT] = y & z;
        f_exp[F7_BIT] = (pop == 3'd2);
    end

endmodule

// File: rtl/bb_sweep_ctrl.sv
// bb_sweep_ctrl
// Steps the breadboard inputs {w,x,y,z} through 0..LAST_IDX, waits SETTLE
// cycles per vector, captures {f2,f3,f4,f7} and hands each result out on a
// valid/ready interface.
// Optional golden check: define BB_SWEEP_CHECK_EN to enable res_err/err_cnt;
// without it both outputs are tied to 0 and bb_golden is not instantiated.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, abort        sweep control (abort wins over everything)
//   w, x, y, z          breadboard drive, {w,x,y,z} == idx
//   f_in                breadboard outputs {f2,f3,f4,f7}
//   res_valid/res_ready result handshake
//   res_idx, res_f      captured vector index and breadboard outputs
//   res_err, err_cnt    golden-model mismatch flag and per-sweep count
//   busy, done          activity flag and one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// APPLY | vector driven, settle counter running
// HOLD  | result presented, waiting for res_ready
// DONE  | done pulse cycle, returns to IDLE
module bb_sweep_ctrl
    import bb_sweep_pkg::*;
#(
    parameter int SETTLE   = 2,
    parameter int LAST_IDX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       w,
    output logic       x,
    output logic       y,
    output logic       z,
    input  logic [3:0] f_in,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_idx,
    output logic [3:0] res_f,
    output logic       res_err,
    output logic [4:0] err_cnt,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);
    localparam logic [3:0] LAST_L   = 4'(LAST_IDX);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] cnt;
    logic       mismatch;

    // idx is registered, so the drive only moves on the edge entering APPLY.
    assign {w, x, y, z} = idx;

`ifdef BB_SWEEP_CHECK_EN
    logic [3:0] f_exp;

    bb_golden u_golden (
        .idx   (idx),
        .f_exp (f_exp)
    );

    assign mismatch = (f_in != f_exp);
`else
    assign mismatch = 1'b0;
    assign res_err  = 1'b0;
    assign err_cnt  = 5'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 4'd0;
            cnt       <= 4'd0;
            res_valid <= 1'b0;
            res_idx   <= 4'd0;
            res_f     <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef BB_SWEEP_CHECK_EN
            res_err   <= 1'b0;
            err_cnt   <= 5'd0;
`endif
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                idx       <= 4'd0;
                res_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            idx   <= 4'd0;
                            cnt   <= SETTLE_L;
                            busy  <= 1'b1;
                            state <= APPLY;
`ifdef BB_SWEEP_CHECK_EN
                            err_cnt <= 5'd0;
`endif
                        end
                    end
                    APPLY: begin
                        // Capture on the edge where the counter reaches zero.
                        if (cnt <= 4'd1) begin
                            cnt       <= 4'd0;
                            res_f     <= f_in;
                            res_idx   <= idx;
                            res_valid <= 1'b1;
                            state     <= HOLD;
`ifdef BB_SWEEP_CHECK_EN
                            res_err <= mismatch;
                            if (mismatch) begin
                                err_cnt <= err_cnt + 5'd1;
                            end
`endif
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    HOLD: begin
                        if (res_valid && res_ready) begin
                            res_valid <= 1'b0;
                            if (idx == LAST_L) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                idx   <= idx + 4'd1;
                                cnt   <= SETTLE_L;
                                state <= APPLY;
                            end
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bb_sweep_ctrl.sv
module tb_bb_sweep_ctrl;

`ifdef BB_SWEEP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       res_ready = 1'b0;
    logic       w, x, y, z;
    logic [3:0] f_in;
    logic       res_valid;
    logic [3:0] res_idx, res_f;
    logic       res_err;
    logic [4:0] err_cnt;
    logic       busy, done;
    logic [3:0] fault_mask = 4'b0000;

    logic       s_start = 1'b0;
    logic       s_abort = 1'b0;
    logic       s_ready = 1'b1;
    logic       s_w, s_x, s_y, s_z;
    logic [3:0] s_f_in;
    logic       s_valid;
    logic [3:0] s_idx, s_f;
    logic       s_err;
    logic [4:0] s_err_cnt;
    logic       s_busy, s_done;

    // Hand-computed breadboard truth table, {f2,f3,f4,f7} per {w,x,y,z}.
    function automatic logic [3:0] bb_ref(input logic [3:0] v);
        logic [3:0] r;
        case (v)
            4'd3:    r = 4'b0011;
            4'd5:    r = 4'b0001;
            4'd6:    r = 4'b0101;
            4'd7:    r = 4'b1110;
            4'd9:    r = 4'b0101;
            4'd10:   r = 4'b0001;
            4'd11:   r = 4'b1110;
            4'd12:   r = 4'b0001;
            4'd13:   r = 4'b1100;
            4'd14:   r = 4'b1100;
            4'd15:   r = 4'b1110;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    assign f_in   = bb_ref({w, x, y, z}) & ~fault_mask;
    assign s_f_in = bb_ref({s_w, s_x, s_y, s_z});

    bb_sweep_ctrl #(.SETTLE(2), .LAST_IDX(15)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .w(w), .x(x), .y(y), .z(z), .f_in(f_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_idx(res_idx), .res_f(res_f), .res_err(res_err),
        .err_cnt(err_cnt), .busy(busy), .done(done)
    );

    bb_sweep_ctrl #(.SETTLE(1), .LAST_IDX(3)) u_short (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
        .w(s_w), .x(s_x), .y(s_y), .z(s_z), .f_in(s_f_in),
        .res_valid(s_valid), .res_ready(s_ready),
        .res_idx(s_idx), .res_f(s_f), .res_err(s_err),
        .err_cnt(s_err_cnt), .busy(s_busy), .done(s_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic tfail(input string name);
        n_chk++;
        $display("FAIL %s: got timeout, required event within budget", name);
    endtask

    typedef struct {
        logic [3:0] idx;
        logic [3:0] f;
        logic       err;
        int         cyc;
    } res_t;

    typedef struct {
        int         cyc;
        logic [4:0] ecnt;
    } done_t;

    res_t  sb[$];
    done_t dq[$];
    res_t  m_e;
    done_t m_d;

    task automatic push_sweep(input int first_cyc, input int last, input logic [3:0] mask,
                              input bit timed);
        res_t e;
        for (int k = 0; k <= last; k++) begin
            e.idx = 4'(k);
            e.f   = bb_ref(4'(k)) & ~mask;
            e.err = CHK && ((bb_ref(4'(k)) & mask) != 4'b0000);
            e.cyc = timed ? first_cyc + 3 * k : -1;
            sb.push_back(e);
        end
    endtask

    task automatic push_done(input int c, input logic [4:0] ecnt);
        done_t d;
        d.cyc  = c;
        d.ecnt = ecnt;
        dq.push_back(d);
    endtask

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result_idx", {28'd0, res_idx}, 32'hFFFF_FFFF);
                end else begin
                    m_e = sb.pop_front();
                    chk("res_idx", {28'd0, res_idx}, {28'd0, m_e.idx});
                    chk("res_f", {28'd0, res_f}, {28'd0, m_e.f});
                    chk("res_err", {31'd0, res_err}, {31'd0, m_e.err});
                    if (m_e.cyc >= 0) chk("res_cycle", cyc, m_e.cyc);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    m_d = dq.pop_front();
                    if (m_d.cyc >= 0) chk("done_cycle", cyc, m_d.cyc);
                    chk("done_err_cnt", {27'd0, err_cnt}, {27'd0, m_d.ecnt});
                end
            end
        end
    end

    // Monitor for the short-sweep instance.
    int s_next = 0;
    int s_done_seen = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid) begin
                chk("short_idx", {28'd0, s_idx}, s_next);
                chk("short_f", {28'd0, s_f}, {28'd0, bb_ref(4'(s_next))});
                chk("short_err", {31'd0, s_err}, 32'd0);
                s_next++;
            end
            if (s_done) begin
                chk("short_count", s_next, 32'd4);
                chk("short_err_cnt", {27'd0, s_err_cnt}, 32'd0);
                s_done_seen++;
            end
        end
    end

    task automatic wait_for_idx(input int n, output int c);
        bit found = 1'b0;
        c = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (res_valid && res_idx == 4'(n)) begin
                found = 1'b1;
                c = cyc;
                break;
            end
        end
        if (!found) tfail($sformatf("wait_idx_%0d", n));
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0 && dq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) tfail(name);
    endtask

    task automatic pulse_start(output int c0);
        @(negedge clk);
        start = 1'b1;
        c0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_idx"}, {28'd0, res_idx}, 32'd0);
        chk({tag, "_f"}, {28'd0, res_f}, 32'd0);
        chk({tag, "_err"}, {31'd0, res_err}, 32'd0);
        chk({tag, "_err_cnt"}, {27'd0, err_cnt}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_wxyz"}, {28'd0, w, x, y, z}, 32'd0);
    endtask

    initial begin
        int c0, c, p;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // 1. Correct sweep, ready tied high, cycle-exact timing.
        res_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        c0 = cyc + 1;
        push_sweep(c0 + 2, 15, 4'b0000, 1'b1);
        push_done(c0 + 48, 5'd0);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        wait_idle("sweep1");

        // 2. Backpressure at idx 4.
        push_sweep(0, 15, 4'b0000, 1'b0);
        push_done(-1, 5'd0);
        pulse_start(c0);
        wait_for_idx(3, c);
        @(posedge clk);
        #1 res_ready = 1'b0;
        wait_for_idx(4, c);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_idx", {28'd0, res_idx}, 32'd4);
            chk("bp_f", {28'd0, res_f}, 32'd0);
            chk("bp_wxyz", {28'd0, w, x, y, z}, 32'd4);
            @(negedge clk);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        p = cyc;
        wait_for_idx(5, c);
        chk("bp_resume_cycle", c, p + 3);
        wait_idle("sweep2");

        // 3. Fault injection: f4 stuck at 0.
        fault_mask = 4'b0010;
        push_sweep(0, 15, fault_mask, 1'b0);
        push_done(-1, CHK ? 5'd4 : 5'd0);
        pulse_start(c0);
        wait_idle("sweep3");

        // 4. Start re-pulse ignored, abort at idx 9 (fault still present).
        push_sweep(0, 8, fault_mask, 1'b0);
        pulse_start(c0);
        wait_for_idx(6, c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", {31'd0, busy}, 32'd1);
        wait_for_idx(8, c);
        @(posedge clk);
        #1 res_ready = 1'b0;
        wait_for_idx(9, c);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_valid", {31'd0, res_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_wxyz", {28'd0, w, x, y, z}, 32'd0);
        chk("abort_err_cnt", {27'd0, err_cnt}, CHK ? 32'd2 : 32'd0);
        chk("abort_sb_drained", sb.size(), 32'd0);
        res_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_still_idle", {31'd0, busy}, 32'd0);
        fault_mask = 4'b0000;

        // 5. Async reset in mid-HOLD, then a fresh timed sweep and short sweep.
        push_sweep(0, 1, 4'b0000, 1'b0);
        pulse_start(c0);
        wait_for_idx(1, c);
        @(posedge clk);
        #1 res_ready = 1'b0;
        wait_for_idx(2, c);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        s_start = 1'b1;
        s_next = 0;
        c0 = cyc + 1;
        push_sweep(c0 + 2, 15, 4'b0000, 1'b1);
        push_done(c0 + 48, 5'd0);
        @(negedge clk);
        start = 1'b0;
        s_start = 1'b0;
        wait_idle("sweep5");
        chk("short_done_count", s_done_seen, 32'd1);
        chk("short_busy_end", {31'd0, s_busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before limit");
        $fatal(1, "global timeout");
    end

endmodule
